// File: rtl/bus_router.sv
// -----------------------------------------------------------------------------
// bus_router
//
// PicoRV32-native bus interconnect. One CPU-side mem_* port fans out to
// N_TARGETS address-decoded target ports. Each target has a base, a decode
// mask and an optional read-only attribute. A per-transaction watchdog bounds
// how long a target may stall. Unmapped accesses, writes to read-only targets
// and timeouts complete towards the CPU with ERR_RDATA and are recorded in a
// small fault log.
//
// Ports
//   clk, resetn        system clock, asynchronous active-low reset
//   cpu_valid          request strobe (picorv32 mem_valid)
//   cpu_instr          instruction-fetch flag, only recorded in the fault log
//   cpu_addr/wdata     request address / write data
//   cpu_wstrb          byte strobes, all-zero means read
//   cpu_ready          one-cycle completion pulse
//   cpu_rdata          read data, valid while cpu_ready is high, else 0
//   tgt_valid          one-hot request to the selected target
//   tgt_addr           offset within the selected region
//   tgt_wdata/wstrb    registered write data / strobes
//   tgt_rdata          per-target read data, target i in bits [32*i +: 32]
//   tgt_ready          per-target completion
//   err_clear          synchronous clear of the fault log
//   err_pulse          one-cycle pulse per fault
//   err_code           last fault: 00 none, 01 unmapped, 10 timeout,
//                      11 write to read-only target
//   err_addr/instr     cpu_addr / cpu_instr of the last fault
//   err_count          saturating fault counter
// -----------------------------------------------------------------------------
module bus_router #(
    parameter int unsigned             N_TARGETS      = 4,
    parameter logic [N_TARGETS*32-1:0] BASES          = {32'hF0000000, 32'h80000000,
                                                         32'h00000000, 32'h00040000},
    parameter logic [N_TARGETS*32-1:0] MASKS          = {32'hFF000000, 32'hFFFF0000,
                                                         32'hFFF80000, 32'hFFFFE000},
    parameter logic [N_TARGETS-1:0]    RO_MASK        = 4'b0001,
    parameter int unsigned             TIMEOUT_CYCLES = 255,
    parameter logic [31:0]             ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      resetn,

    input  logic                      cpu_valid,
    input  logic                      cpu_instr,
    input  logic [31:0]               cpu_addr,
    input  logic [31:0]               cpu_wdata,
    input  logic [3:0]                cpu_wstrb,
    output logic                      cpu_ready,
    output logic [31:0]               cpu_rdata,

    output logic [N_TARGETS-1:0]      tgt_valid,
    output logic [31:0]               tgt_addr,
    output logic [31:0]               tgt_wdata,
    output logic [3:0]                tgt_wstrb,
    input  logic [N_TARGETS*32-1:0]   tgt_rdata,
    input  logic [N_TARGETS-1:0]      tgt_ready,

    input  logic                      err_clear,
    output logic                      err_pulse,
    output logic [1:0]                err_code,
    output logic [31:0]               err_addr,
    output logic                      err_instr,
    output logic [15:0]               err_count
);

    localparam int unsigned SEL_W = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1;
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_FAULT  = 2'b10,
        ST_RESP   = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_UNMAPPED = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_READONLY = 2'b11
    } err_code_t;

    // FSM state
    state_t          r_state;
    state_t          w_next_state;

    // Latched request
    logic [SEL_W-1:0] r_sel;
    logic [31:0]      r_addr;
    logic             r_instr;
    logic [31:0]      r_tgt_addr;
    logic [31:0]      r_tgt_wdata;
    logic [3:0]       r_tgt_wstrb;

    // Response / watchdog
    logic [31:0]      r_rdata;
    logic [WD_W-1:0]  r_wd;
    err_code_t        r_fault_code;

    // Fault log
    err_code_t        r_err_code;
    logic [31:0]      r_err_addr;
    logic             r_err_instr;
    logic [15:0]      r_err_count;

    // Decode of the live CPU address
    logic             w_hit;
    logic [SEL_W-1:0] w_sel;
    logic [31:0]      w_offset;
    logic             w_ro_violation;

    // Selected-target view while ACTIVE
    logic             w_sel_ready;
    logic [31:0]      w_sel_rdata;
    logic             w_wd_expired;

    // -------------------------------------------------------------------------
    // Address decode. Scanning from the highest index down lets the lowest
    // matching index overwrite the others, so the boot ROM window shadows the
    // SRAM region it sits inside.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        w_hit    = 1'b0;
        w_sel    = '0;
        w_offset = '0;
        for (int i = int'(N_TARGETS) - 1; i >= 0; i--) begin
            if ((cpu_addr & MASKS[i*32 +: 32]) == BASES[i*32 +: 32]) begin
                w_hit    = 1'b1;
                w_sel    = SEL_W'(i);
                w_offset = cpu_addr & ~MASKS[i*32 +: 32];
            end
        end
    end

    assign w_ro_violation = w_hit && RO_MASK[w_sel] && (cpu_wstrb != 4'b0000);

    // Ready/rdata of the latched target only; other ports' ready is ignored.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < int'(N_TARGETS); i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_ready = tgt_ready[i];
                w_sel_rdata = tgt_rdata[i*32 +: 32];
            end
        end
    end

    assign w_wd_expired = (r_wd == WD_LIMIT);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        err_pulse    = 1'b0;
        tgt_valid    = '0;

        unique case (r_state)
            ST_IDLE: begin
                if (cpu_valid) begin
                    if (!w_hit || w_ro_violation) begin
                        w_next_state = ST_FAULT;
                    end else begin
                        w_next_state = ST_ACTIVE;
                    end
                end
            end

            ST_ACTIVE: begin
                for (int i = 0; i < int'(N_TARGETS); i++) begin
                    tgt_valid[i] = (r_sel == SEL_W'(i));
                end
                // Ready takes priority over an expiring watchdog.
                if (w_sel_ready) begin
                    w_next_state = ST_RESP;
                end else if (w_wd_expired) begin
                    w_next_state = ST_FAULT;
                end
            end

            ST_FAULT: begin
                err_pulse    = 1'b1;
                w_next_state = ST_RESP;
            end

            ST_RESP: begin
                cpu_ready    = 1'b1;
                cpu_rdata    = r_rdata;
                w_next_state = ST_IDLE;
            end

            default: w_next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request latch, watchdog and response data
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sel        <= '0;
            r_addr       <= '0;
            r_instr      <= 1'b0;
            r_tgt_addr   <= '0;
            r_tgt_wdata  <= '0;
            r_tgt_wstrb  <= '0;
            r_rdata      <= '0;
            r_wd         <= '0;
            r_fault_code <= ERR_NONE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu_valid) begin
                        r_sel       <= w_sel;
                        r_addr      <= cpu_addr;
                        r_instr     <= cpu_instr;
                        r_tgt_addr  <= w_offset;
                        r_tgt_wdata <= cpu_wdata;
                        r_tgt_wstrb <= cpu_wstrb;
                        r_wd        <= '0;
                        if (!w_hit) begin
                            r_fault_code <= ERR_UNMAPPED;
                        end else if (w_ro_violation) begin
                            r_fault_code <= ERR_READONLY;
                        end else begin
                            r_fault_code <= ERR_NONE;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (w_sel_ready) begin
                        r_rdata <= w_sel_rdata;
                    end else if (w_wd_expired) begin
                        r_fault_code <= ERR_TIMEOUT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end

                ST_FAULT: begin
                    r_rdata <= ERR_RDATA;
                end

                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Fault log. A fault in the same cycle as err_clear wins over the clear
    // for the sticky fields and restarts the counter at 1.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_code  <= ERR_NONE;
            r_err_addr  <= '0;
            r_err_instr <= 1'b0;
            r_err_count <= '0;
        end else if (r_state == ST_FAULT) begin
            r_err_code  <= r_fault_code;
            r_err_addr  <= r_addr;
            r_err_instr <= r_instr;
            if (err_clear) begin
                r_err_count <= 16'd1;
            end else if (r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end else if (err_clear) begin
            r_err_code  <= ERR_NONE;
            r_err_addr  <= '0;
            r_err_instr <= 1'b0;
            r_err_count <= '0;
        end
    end

    assign tgt_addr  = r_tgt_addr;
    assign tgt_wdata = r_tgt_wdata;
    assign tgt_wstrb = r_tgt_wstrb;
    assign err_code  = r_err_code;
    assign err_addr  = r_err_addr;
    assign err_instr = r_err_instr;
    assign err_count = r_err_count;

endmodule
